// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, hazard-controller FSM encoding and operand-use decode.
package pipeline_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned REG_W    = 5;

   typedef logic [OPCODE_W-1:0] opcode_t;
   typedef logic [REG_W-1:0]    reg_idx_t;

   localparam opcode_t RTYPE = 6'h00;
   localparam opcode_t J     = 6'h02;
   localparam opcode_t JAL   = 6'h03;
   localparam opcode_t BEQ   = 6'h04;
   localparam opcode_t BNE   = 6'h05;
   localparam opcode_t LW    = 6'h23;
   localparam opcode_t SW    = 6'h2B;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   function automatic logic is_mem(input opcode_t op);
      return (op == LW) || (op == SW);
   endfunction

   function automatic logic rs_used(input opcode_t op);
      return !((op == J) || (op == JAL));
   endfunction

   function automatic logic rt_used(input opcode_t op);
      return (op == RTYPE) || (op == SW) || (op == BEQ) || (op == BNE);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Stage-status inputs and pipeline-register controls between the datapath and the hazard controller.
interface pipeline_hazard_controller_if #(
   parameter int unsigned PERF_W = 16
);

   pipeline_pkg::opcode_t  id_opcode;
   pipeline_pkg::reg_idx_t id_rs;
   pipeline_pkg::reg_idx_t id_rt;
   pipeline_pkg::opcode_t  ex_opcode;
   pipeline_pkg::reg_idx_t ex_rd;
   logic                   ex_reg_write;
   logic                   ex_branch_taken;
   pipeline_pkg::opcode_t  mem_opcode;
   pipeline_pkg::reg_idx_t mem_rd;
   logic                   mem_reg_write;
   logic                   mem_ready;

   logic                   mem_req;
   logic                   pc_en;
   logic                   ifid_en;
   logic                   idex_en;
   logic                   exmem_en;
   logic                   ifid_flush;
   logic                   idex_flush;
   logic                   memwb_bubble;
   logic                   mem_err;
   logic [PERF_W-1:0]      stall_cycles;

   modport master (
      output id_opcode, id_rs, id_rt, ex_opcode, ex_rd, ex_reg_write, ex_branch_taken,
             mem_opcode, mem_rd, mem_reg_write, mem_ready,
      input  mem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
             memwb_bubble, mem_err, stall_cycles
   );

   modport slave (
      input  id_opcode, id_rs, id_rt, ex_opcode, ex_rd, ex_reg_write, ex_branch_taken,
             mem_opcode, mem_rd, mem_reg_write, mem_ready,
      output mem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
             memwb_bubble, mem_err, stall_cycles
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW comparator for the instruction in ID.
// FORWARD_EN defined: only a load in EX stalls; undefined: any pending write in EX or MEM stalls.
module hazard_detect
   import pipeline_pkg::*;
(
   input  opcode_t  id_opcode,
   input  reg_idx_t id_rs,
   input  reg_idx_t id_rt,
   input  opcode_t  ex_opcode,
   input  reg_idx_t ex_rd,
   input  logic     ex_reg_write,
   input  reg_idx_t mem_rd,
   input  logic     mem_reg_write,
   output logic     stall_c
);

   logic rs_use;
   logic rt_use;
   logic ex_match;
   logic mem_match;

   assign rs_use = rs_used(id_opcode);
   assign rt_use = rt_used(id_opcode);

   // r0 is hardwired, so a write to it never creates a dependency
   assign ex_match  = (ex_rd != '0) &&
                      ((rs_use && (ex_rd == id_rs)) || (rt_use && (ex_rd == id_rt)));
   assign mem_match = (mem_rd != '0) &&
                      ((rs_use && (mem_rd == id_rs)) || (rt_use && (mem_rd == id_rt)));

`ifdef FORWARD_EN
   assign stall_c = ex_reg_write && ex_match && (ex_opcode == LW);

   logic unused_mem;
   assign unused_mem = mem_reg_write ^ mem_match;
`else
   assign stall_c = (ex_reg_write && ex_match) || (mem_reg_write && mem_match);

   logic unused_ex_op;
   assign unused_ex_op = ^ex_opcode;
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer: memory-wait FSM with timeout, branch squash, RAW stalls, stall counter.
// Build option FORWARD_EN (in hazard_detect) narrows stalls to load-use only.
module pipeline_hazard_controller
   import pipeline_pkg::*;
#(
   parameter int unsigned WAIT_W      = 8,
   parameter int unsigned MEM_TIMEOUT = 200,
   parameter int unsigned PERF_W      = 16
) (
   input logic                         clk,
   input logic                         reset,
   pipeline_hazard_controller_if.slave bus
);

   state_t            state_q;
   state_t            state_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              err_q;
   logic              err_d;
   logic [PERF_W-1:0] stall_q;

   logic              freeze;
   logic              load_use_c;
   logic              req;
   logic              pc_en;
   logic              ifid_en;
   logic              idex_en;
   logic              exmem_en;
   logic              ifid_flush;
   logic              idex_flush;
   logic              memwb_bubble;

   hazard_detect u_hazard_detect (
      .id_opcode     (bus.id_opcode),
      .id_rs         (bus.id_rs),
      .id_rt         (bus.id_rt),
      .ex_opcode     (bus.ex_opcode),
      .ex_rd         (bus.ex_rd),
      .ex_reg_write  (bus.ex_reg_write),
      .mem_rd        (bus.mem_rd),
      .mem_reg_write (bus.mem_reg_write),
      .stall_c       (load_use_c)
   );

   // State register and wait/error bookkeeping
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Next state and same-cycle pipeline controls
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      err_d        = err_q;
      freeze       = 1'b0;
      req          = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;

      case (state_q)
         RUN: begin
            req = is_mem(bus.mem_opcode);
            if (req && !bus.mem_ready) begin
               freeze  = 1'b1;
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            req = 1'b1;
            if (bus.mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
               // abandon the access and let the pipeline move on as if it had completed
               err_d   = 1'b1;
               state_d = RUN;
               wait_d  = '0;
            end else begin
               freeze  = 1'b1;
               wait_d  = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase

      if (freeze) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use_c) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end

      if (!reset) begin
         req          = 1'b0;
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         memwb_bubble = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC is held
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (!pc_en && (stall_q != '1)) begin
         stall_q <= stall_q + PERF_W'(1);
      end
   end

   assign bus.mem_req      = req;
   assign bus.pc_en        = pc_en;
   assign bus.ifid_en      = ifid_en;
   assign bus.idex_en      = idex_en;
   assign bus.exmem_en     = exmem_en;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_flush   = idex_flush;
   assign bus.memwb_bubble = memwb_bubble;
   assign bus.mem_err      = err_q;
   assign bus.stall_cycles = stall_q;

endmodule
